// File: rtl/bambu_slave_master_if.sv
// Host command/response, run control and core slave-memory bus for bambu_slave_master.
interface bambu_slave_master_if #(
  parameter int CNT_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [6:0]       cmd_addr;
  logic [7:0]       cmd_wdata;
  logic             rsp_valid;
  logic [7:0]       rsp_rdata;
  logic             rsp_timeout;
  logic             run_req;
  logic             run_done;
  logic [CNT_W-1:0] run_cycles;
  logic             busy;
  logic             start_port;
  logic             done_port;
  logic [1:0]       S_oe_ram;
  logic [1:0]       S_we_ram;
  logic [13:0]      S_addr_ram;
  logic [15:0]      S_Wdata_ram;
  logic [7:0]       S_data_ram_size;
  logic [15:0]      Sout_Rdata_ram;
  logic [1:0]       Sout_DataRdy;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, run_req, done_port,
           Sout_Rdata_ram, Sout_DataRdy,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, run_done, run_cycles, busy,
           start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, run_req, done_port,
           Sout_Rdata_ram, Sout_DataRdy,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, run_done, run_cycles, busy,
           start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size
  );
endinterface

// File: rtl/bambu_slave_master.sv
// Host-side master for a Bambu core: byte accesses into core memory over slave channel 0,
// and single-shot core runs with cycle counting.
//   state | meaning
//   IDLE  | ready for a host access or a run request
//   WR    | write enable held on channel 0 until DataRdy or timeout
//   RD    | read enable held on channel 0 until DataRdy or timeout
//   RUN   | core executing, cycle counter advancing
//   FIN   | run_done pulse, back to IDLE next cycle
module bambu_slave_master #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input logic                  clock,
  input logic                  reset,
  bambu_slave_master_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WR, RD, RUN, FIN} state_e;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             start_q, start_d;
  logic             run_done_q, run_done_d;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wait_d        = wait_q;
    run_cnt_d     = run_cnt_q;
    run_cycles_d  = run_cycles_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    start_d       = 1'b0;
    run_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // A host access wins over a run request arriving in the same cycle.
        if (bus.cmd_valid) begin
          state_d = bus.cmd_write ? WR : RD;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          wait_d  = '0;
        end else if (bus.run_req) begin
          state_d   = RUN;
          start_d   = 1'b1;
          run_cnt_d = CNT_W'(1);
        end
      end
      WR, RD: begin
        if (bus.Sout_DataRdy[0]) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (state_q == RD) ? bus.Sout_Rdata_ram[7:0] : 8'h00;
        end else if (wait_q == WAIT_LAST) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = 8'h00;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.done_port) begin
          state_d      = FIN;
          run_cycles_d = run_cnt_q;
          run_done_d   = 1'b1;
        end else if (run_cnt_q != '1) begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wait_q        <= '0;
      run_cnt_q     <= '0;
      run_cycles_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      start_q       <= 1'b0;
      run_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wait_q        <= wait_d;
      run_cnt_q     <= run_cnt_d;
      run_cycles_q  <= run_cycles_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      start_q       <= start_d;
      run_done_q    <= run_done_d;
    end
  end

  logic in_wr, in_rd, in_acc;
  assign in_wr  = (state_q == WR);
  assign in_rd  = (state_q == RD);
  assign in_acc = in_wr | in_rd;

  // Channel 1 is never used; its slices stay tied to zero.
  assign bus.S_we_ram        = {1'b0, in_wr};
  assign bus.S_oe_ram        = {1'b0, in_rd};
  assign bus.S_addr_ram      = {7'd0, in_acc ? addr_q : 7'd0};
  assign bus.S_Wdata_ram     = {8'd0, in_wr ? wdata_q : 8'd0};
  assign bus.S_data_ram_size = {4'd0, in_acc ? 4'd8 : 4'd0};

  assign bus.cmd_ready   = (state_q == IDLE) & ~reset;
  assign bus.busy        = (state_q != IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.start_port  = start_q;
  assign bus.run_done    = run_done_q;
  assign bus.run_cycles  = run_cycles_q;

  logic unused_in;
  assign unused_in = ^{bus.Sout_Rdata_ram[15:8], bus.Sout_DataRdy[1]};

endmodule

// File: tb/tb_bambu_slave_master.sv
// Self-checking bench for bambu_slave_master: table vectors, hand sequences and
// randomized accesses/runs checked against a transaction-level model.
module tb_bambu_slave_master;
  localparam int T = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bambu_slave_master_if #(.CNT_W(32)) bus ();
  bambu_slave_master #(.TIMEOUT(T), .CNT_W(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  bambu_slave_master_if #(.CNT_W(4)) bus_s ();
  bambu_slave_master #(.TIMEOUT(T), .CNT_W(4)) dut_s (.clock(clock), .reset(reset), .bus(bus_s));

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [128];

  typedef struct {
    bit          wr;
    logic [6:0]  a;
    logic [7:0]  d;
    int          lat;
    logic [15:0] sout;
    bit          with_run;
    int          exp_en;
    bit          exp_to;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [87:0] all_outs();
    return {bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout, bus.run_done,
            bus.run_cycles, bus.busy, bus.start_port, bus.S_oe_ram, bus.S_we_ram,
            bus.S_addr_ram, bus.S_Wdata_ram, bus.S_data_ram_size};
  endfunction

  function automatic bit s_nonzero();
    return (bus.S_oe_ram != 0) || (bus.S_we_ram != 0) || (bus.S_addr_ram != 0) ||
           (bus.S_Wdata_ram != 0) || (bus.S_data_ram_size != 0);
  endfunction

  // One host access; the bench plays the core slave and raises DataRdy[0] in access cycle v.lat.
  task automatic access(input string nm, input vec_t v);
    int         en = 0;
    bit         got = 0;
    bit         hold_bad = 0;
    bit         start_seen = 0;
    logic [7:0] rd = 8'h00;
    logic       to = 1'b0;
    chk({nm, "_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.a;
    bus.cmd_wdata = v.d;
    bus.run_req   = v.with_run;
    step();
    bus.cmd_valid = 1'b0;
    bus.run_req   = 1'b0;
    bus.cmd_addr  = 7'($urandom);
    bus.cmd_wdata = 8'($urandom);
    for (int k = 0; k < T + 6 && !got; k++) begin
      if (bus.start_port) start_seen = 1;
      if (bus.rsp_valid) begin
        got = 1;
        rd  = bus.rsp_rdata;
        to  = bus.rsp_timeout;
        chk({nm, "_en_drop"}, {bus.S_we_ram, bus.S_oe_ram}, 0);
      end else begin
        if (bus.S_we_ram != 0 || bus.S_oe_ram != 0) begin
          en++;
          if ((v.wr ? bus.S_we_ram : bus.S_oe_ram) !== 2'b01 ||
              (v.wr ? bus.S_oe_ram : bus.S_we_ram) !== 2'b00 ||
              bus.S_addr_ram !== {7'd0, v.a} || bus.S_data_ram_size !== 8'h08 ||
              (v.wr && bus.S_Wdata_ram !== {8'h00, v.d}))
            hold_bad = 1;
        end
        bus.Sout_Rdata_ram = v.sout;
        bus.Sout_DataRdy   = {1'($urandom), (k == v.lat)};
        if (v.wr && k == v.lat) mem[v.a] = v.d;
        step();
      end
    end
    bus.Sout_DataRdy = 2'b00;
    chk({nm, "_rsp_seen"}, got, 1);
    chk({nm, "_en_cycles"}, en, v.exp_en);
    chk({nm, "_timeout"}, to, v.exp_to);
    chk({nm, "_rdata"}, rd, v.exp_rd);
    chk({nm, "_hold"}, hold_bad, 0);
    chk({nm, "_no_start"}, start_seen, 0);
    step();
    chk({nm, "_rsp_pulse"}, {bus.rsp_valid, bus.busy, bus.start_port}, 0);
  endtask

  // One core run; done_port raised d cycles after the start_port cycle.
  task automatic run(input string nm, input int d, input bit poke);
    int          starts = 0;
    bit          got = 0;
    bit          s_bad = 0;
    bit          rsp_bad = 0;
    logic [31:0] rc = 0;
    bus.run_req = 1'b1;
    step();
    bus.run_req = 1'b0;
    chk({nm, "_busy"}, {bus.busy, bus.cmd_ready}, 2'b10);
    for (int k = 0; k < d + 6 && !got; k++) begin
      if (bus.start_port) starts++;
      if (s_nonzero()) s_bad = 1;
      if (bus.rsp_valid) rsp_bad = 1;
      if (bus.run_done) begin
        got = 1;
        rc  = bus.run_cycles;
        chk({nm, "_busy_fin"}, bus.busy, 1);
      end else begin
        bus.done_port    = (k == d);
        bus.run_req      = poke && (k == 1);
        bus.Sout_DataRdy = 2'($urandom);
        step();
        bus.done_port = 1'b0;
        bus.run_req   = 1'b0;
      end
    end
    bus.Sout_DataRdy = 2'b00;
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_starts"}, starts, 1);
    chk({nm, "_cycles"}, rc, d + 1);
    chk({nm, "_s_quiet"}, {s_bad, rsp_bad}, 0);
    step();
    chk({nm, "_after"}, {bus.run_done, bus.busy, bus.start_port, bus.cmd_ready}, 4'b0001);
    chk({nm, "_held"}, bus.run_cycles, d + 1);
  endtask

  initial begin
    vec_t v;
    bit   seen;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.run_req = 0; bus.done_port = 0; bus.Sout_Rdata_ram = 0; bus.Sout_DataRdy = 0;
    bus_s.cmd_valid = 0; bus_s.cmd_write = 0; bus_s.cmd_addr = 0; bus_s.cmd_wdata = 0;
    bus_s.run_req = 0; bus_s.done_port = 0; bus_s.Sout_Rdata_ram = 0; bus_s.Sout_DataRdy = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

    //          wr    addr    data   lat sout      run exp_en to  rdata
    vecs[0] = '{1'b1, 7'h05, 8'hA7, 1,  16'h0000, 0, 2,     0, 8'h00};
    vecs[1] = '{1'b0, 7'h7F, 8'h00, 0,  16'hFF3C, 0, 1,     0, 8'h3C};
    vecs[2] = '{1'b0, 7'h10, 8'h00, 99, 16'h5555, 0, T,     1, 8'h00};
    vecs[3] = '{1'b0, 7'h22, 8'h00, T-1,16'h1234, 0, T,     0, 8'h34};
    vecs[4] = '{1'b1, 7'h00, 8'hFF, T,  16'h0000, 0, T,     1, 8'h00};
    vecs[5] = '{1'b1, 7'h7F, 8'h5A, 0,  16'h0000, 1, 1,     0, 8'h00};
    vecs[6] = '{1'b0, 7'h00, 8'h00, 2,  16'hABCD, 1, 3,     0, 8'hCD};
    vecs[7] = '{1'b0, 7'h41, 8'h00, 0,  16'h8000, 0, 1,     0, 8'h00};

    reset = 1'b1;
    #12;
    chk("reset_outs", all_outs(), 0);
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("reset_release", {bus.cmd_ready, bus.busy, bus.run_cycles}, {1'b1, 1'b0, 32'd0});

    for (int i = 0; i < 8; i++) access($sformatf("vec%0d", i), vecs[i]);

    run("run9", 9, 1);
    run("run0", 0, 0);

    // Saturating counter on the narrow-counter instance.
    bus_s.run_req = 1'b1;
    step();
    bus_s.run_req = 1'b0;
    repeat (20) step();
    bus_s.done_port = 1'b1;
    step();
    bus_s.done_port = 1'b0;
    chk("sat_cycles", {bus_s.run_done, bus_s.run_cycles}, {1'b1, 4'hF});

    // Reset in the middle of a read.
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 7'h33;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("mid_rd_oe", bus.S_oe_ram, 2'b01);
    #2 reset = 1'b1;
    #1 chk("mid_rd_reset_outs", all_outs(), 0);
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("mid_rd_release", {bus.cmd_ready, bus.busy}, 2'b10);
    seen = 0;
    repeat (6) begin
      if (bus.rsp_valid) seen = 1;
      step();
    end
    chk("mid_rd_no_rsp", seen, 0);

    // Reset in the middle of a run, after a finished run left run_cycles non-zero.
    run("run3", 3, 0);
    bus.run_req = 1'b1;
    step();
    bus.run_req = 1'b0;
    step(); step();
    chk("mid_run_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1 chk("mid_run_reset_outs", all_outs(), 0);
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("mid_run_release", {bus.cmd_ready, bus.busy, bus.run_cycles}, {1'b1, 1'b0, 32'd0});
    seen = 0;
    bus.done_port = 1'b1;
    repeat (6) begin
      if (bus.run_done || bus.start_port) seen = 1;
      step();
    end
    bus.done_port = 1'b0;
    chk("mid_run_no_done", seen, 0);

    // Randomized traffic against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 2);
      if (kind == 2) begin
        run($sformatf("rnd%0d_run", i), $urandom_range(0, 12), 1'($urandom));
      end else begin
        v.wr       = (kind == 1);
        v.a        = 7'($urandom);
        v.d        = 8'($urandom);
        v.lat      = $urandom_range(0, T + 1);
        v.with_run = 1'($urandom);
        v.exp_to   = (v.lat >= T);
        v.exp_en   = v.exp_to ? T : v.lat + 1;
        v.sout     = {8'($urandom), mem[v.a]};
        v.exp_rd   = (v.wr || v.exp_to) ? 8'h00 : mem[v.a];
        access($sformatf("rnd%0d_%s", i, v.wr ? "wr" : "rd"), v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
